// File: rtl/hilo_write_arbiter.sv
// hilo_write_arbiter
//
// Shares the single register-file write port between the pipeline
// writeback (MEM/WB) and a mul/div unit that produces {hi,lo} result pairs.
// Results are queued in a small in-order FIFO. Each entry is drained as two
// consecutive writes: $hi (index 32), then $lo (index 33). Pipeline
// writeback normally wins the port. If it wins STARVE_LIMIT cycles in a row
// while a result is waiting, the pipeline is held for one cycle so that the
// pending $hi/$lo write can go through.
//
// Parameters
//   DEPTH         number of queued {hi,lo} entries (1..4)
//   STARVE_LIMIT  consecutive lost cycles before writeback is held
//
// Ports
//   clock     single clock, rising edge
//   reset     synchronous, active-high
//   wb_we     pipeline writeback request
//   wb_addr   writeback destination register (0..31)
//   wb_data   writeback data
//   md_valid  mul/div result offered this cycle
//   md_hi     $hi half of the offered result
//   md_lo     $lo half of the offered result
//   md_ready  result accepted this cycle (FIFO not full)
//   rf_we     register file write enable
//   rf_addr   register file write index (0-31 GPR, 32 = $hi, 33 = $lo)
//   rf_data   register file write data
//   wb_hold   freeze MEM/WB; the writeback is re-presented next cycle
//   md_busy   $hi/$lo writes pending (mfhi/mflo hazard stall)
module hilo_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        md_valid,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        md_ready,
    output logic        rf_we,
    output logic [5:0]  rf_addr,
    output logic [31:0] rf_data,
    output logic        wb_hold,
    output logic        md_busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_HI = 2'd1,
        WR_LO = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [STV_W-1:0] starve_reg, starve_next;

    logic [31:0] hi_mem [DEPTH];
    logic [31:0] lo_mem [DEPTH];

    logic wb_req;
    logic wb_wins;
    logic push;
    logic pop;

    // Register 0 is hard-wired to zero, so such a writeback is not a request.
    assign wb_req   = wb_we && (wb_addr != 5'd0);
    // Readiness depends only on the current count: a full FIFO refuses a
    // result even in the cycle its head is popped.
    assign md_ready = (count_reg < FULL_CNT) && !reset;
    assign push     = md_valid && md_ready;
    assign wb_hold  = (state_reg != IDLE) && (starve_reg == STV_LIMIT) && wb_req && !reset;
    assign wb_wins  = wb_req && !wb_hold;
    assign md_busy  = (count_reg != '0) && !reset;

    // Arbitration and next-state logic.
    always_comb begin
        state_next  = state_reg;
        starve_next = starve_reg;
        pop         = 1'b0;
        rf_we       = 1'b0;
        rf_addr     = 6'd0;
        rf_data     = 32'd0;

        case (state_reg)
            IDLE: begin
                if (wb_req) begin
                    rf_we   = 1'b1;
                    rf_addr = {1'b0, wb_addr};
                    rf_data = wb_data;
                end
                if (count_reg != '0) begin
                    state_next = WR_HI;
                end
            end
            WR_HI: begin
                if (wb_wins) begin
                    rf_we   = 1'b1;
                    rf_addr = {1'b0, wb_addr};
                    rf_data = wb_data;
                    if (starve_reg != STV_LIMIT) begin
                        starve_next = starve_reg + STV_W'(1);
                    end
                end else begin
                    rf_we       = 1'b1;
                    rf_addr     = 6'd32;
                    rf_data     = hi_mem[rd_ptr_reg];
                    starve_next = '0;
                    state_next  = WR_LO;
                end
            end
            WR_LO: begin
                if (wb_wins) begin
                    rf_we   = 1'b1;
                    rf_addr = {1'b0, wb_addr};
                    rf_data = wb_data;
                    if (starve_reg != STV_LIMIT) begin
                        starve_next = starve_reg + STV_W'(1);
                    end
                end else begin
                    rf_we       = 1'b1;
                    rf_addr     = 6'd33;
                    rf_data     = lo_mem[rd_ptr_reg];
                    starve_next = '0;
                    pop         = 1'b1;
                    // Stay busy if another entry remains after the pop,
                    // including one being pushed in this same cycle.
                    state_next  = ((count_reg > CNT_W'(1)) || push) ? WR_HI : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (reset) begin
            rf_we   = 1'b0;
            rf_addr = 6'd0;
            rf_data = 32'd0;
            pop     = 1'b0;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            starve_reg <= '0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            starve_reg <= starve_next;
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    // Entry storage; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            hi_mem[wr_ptr_reg] <= md_hi;
            lo_mem[wr_ptr_reg] <= md_lo;
        end
    end

endmodule

// File: tb/tb_hilo_write_arbiter.sv
// Testbench for hilo_write_arbiter. Directed scenarios followed by random
// traffic; every cycle's outputs are compared against a reference model
// that tracks pending $hi/$lo writes as a queue of register writes.
module tb_hilo_write_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_valid;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic        md_ready;
    logic        rf_we;
    logic [5:0]  rf_addr;
    logic [31:0] rf_data;
    logic        wb_hold;
    logic        md_busy;

    hilo_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clock    (clock),
        .reset    (reset),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .md_valid (md_valid),
        .md_hi    (md_hi),
        .md_lo    (md_lo),
        .md_ready (md_ready),
        .rf_we    (rf_we),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data),
        .wb_hold  (wb_hold),
        .md_busy  (md_busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: pending register writes ({index,data}) in issue
    // order, whether the arbiter is currently draining, and the run of
    // consecutive writeback wins.
    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t items[$];
    bit  engaged = 1'b0;
    int  starve  = 0;

    task automatic cyc(input string tag, input logic r, input logic we,
                       input logic [4:0] a, input logic [31:0] d,
                       input logic v, input logic [31:0] h, input logic [31:0] l);
        int          cnt;
        logic        req;
        logic        e_we, e_rdy, e_hold, e_busy;
        logic [5:0]  e_a;
        logic [31:0] e_d;
        bit          wrote_lo;
        wr_t         w;
        logic [41:0] obs, exp;

        @(negedge clock);
        reset = r; wb_we = we; wb_addr = a; wb_data = d;
        md_valid = v; md_hi = h; md_lo = l;
        #1;

        cnt = (items.size() + 1) / 2;
        e_we = 1'b0; e_a = 6'd0; e_d = 32'd0;
        e_rdy = 1'b0; e_hold = 1'b0; e_busy = 1'b0;
        wrote_lo = 1'b0;
        req = we && (a != 5'd0);

        if (r) begin
            items.delete();
            engaged = 1'b0;
            starve  = 0;
        end else begin
            e_rdy  = (cnt < DEPTH);
            e_busy = (cnt != 0);
            if (!engaged) begin
                if (req) begin
                    e_we = 1'b1; e_a = {1'b0, a}; e_d = d;
                end
            end else begin
                e_hold = req && (starve == LIMIT);
                if (req && !e_hold) begin
                    e_we = 1'b1; e_a = {1'b0, a}; e_d = d;
                    if (starve < LIMIT) starve++;
                end else begin
                    w = items.pop_front();
                    e_we = 1'b1; e_a = w.a; e_d = w.d;
                    wrote_lo = (w.a == 6'd33);
                    starve = 0;
                end
            end
            if (v && e_rdy) begin
                items.push_back({6'd32, h});
                items.push_back({6'd33, l});
            end
            if (!engaged)      engaged = (cnt > 0);
            else if (wrote_lo) engaged = (items.size() > 0);
        end

        obs = {rf_we, rf_addr, rf_data, md_ready, wb_hold, md_busy};
        exp = {e_we, e_a, e_d, e_rdy, e_hold, e_busy};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed we=%b addr=%0d data=%h rdy=%b hold=%b busy=%b, expected we=%b addr=%0d data=%h rdy=%b hold=%b busy=%b",
                   tag, rf_we, rf_addr, rf_data, md_ready, wb_hold, md_busy,
                   e_we, e_a, e_d, e_rdy, e_hold, e_busy);
        end
        $display("[%0t] %s r=%b wb=%b/%0d v=%b -> we=%b addr=%0d data=%h rdy=%b hold=%b busy=%b",
                 $time, tag, r, we, a, v, rf_we, rf_addr, rf_data, md_ready, wb_hold, md_busy);
    endtask

    initial begin
        reset = 1'b1; wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        md_valid = 1'b0; md_hi = 32'd0; md_lo = 32'd0;

        // Reset state
        cyc("reset0", 1, 0, 0, 0, 0, 0, 0);
        cyc("reset1", 1, 1, 5'd7, 32'h1234, 1, 32'h1, 32'h2);

        // Idle pass-through, and register 0 suppression
        cyc("pass_r5", 0, 1, 5'd5, 32'hA5A5_0001, 0, 0, 0);
        cyc("pass_r0", 0, 1, 5'd0, 32'hDEAD_BEEF, 0, 0, 0);

        // Single result, no writeback traffic
        cyc("single_push", 0, 0, 0, 0, 1, 32'h11, 32'h22);
        for (int i = 0; i < 4; i++) cyc("single_drain", 0, 0, 0, 0, 0, 0, 0);

        // Back-to-back results; third offer meets a full FIFO
        cyc("b2b_push0", 0, 0, 0, 0, 1, 32'hA0, 32'hB0);
        cyc("b2b_push1", 0, 0, 0, 0, 1, 32'hA1, 32'hB1);
        cyc("b2b_full",  0, 0, 0, 0, 1, 32'hA2, 32'hB2);
        for (int i = 0; i < 6; i++) cyc("b2b_drain", 0, 0, 0, 0, 0, 0, 0);

        // Starvation: continuous writeback from the start of draining
        cyc("starve_push", 0, 0, 0, 0, 1, 32'h5151, 32'h5252);
        for (int i = 0; i < 20; i++)
            cyc("starve", 0, 1, 5'(1 + (i % 31)), 32'hC000_0000 + 32'(i), 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("starve_idle", 0, 0, 0, 0, 0, 0, 0);

        // Reset between the $hi and $lo writes
        cyc("rst_mid_push", 0, 0, 0, 0, 1, 32'h77, 32'h88);
        cyc("rst_mid_idle", 0, 0, 0, 0, 0, 0, 0);
        cyc("rst_mid_hi",   0, 0, 0, 0, 0, 0, 0);
        cyc("rst_mid_rst",  1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("rst_mid_after", 0, 0, 0, 0, 0, 0, 0);

        // Full FIFO while popping
        cyc("fullpop_push0", 0, 0, 0, 0, 1, 32'hE0, 32'hF0);
        cyc("fullpop_push1", 0, 0, 0, 0, 1, 32'hE1, 32'hF1);
        cyc("fullpop_hi",    0, 0, 0, 0, 0, 0, 0);
        cyc("fullpop_lo",    0, 0, 0, 0, 1, 32'hE2, 32'hF2);
        cyc("fullpop_acc",   0, 0, 0, 0, 1, 32'hE2, 32'hF2);
        for (int i = 0; i < 8; i++) cyc("fullpop_drain", 0, 0, 0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            logic        r, we, v;
            logic [4:0]  a;
            r  = ($urandom_range(63) == 0);
            we = ($urandom_range(99) < 60);
            a  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            v  = ($urandom_range(99) < 30);
            cyc("random", r, we, a, $urandom, v, $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_write_arbiter.md
HILO_WRITE_ARBITER -- requirements
Module: hilo_write_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the number of pending {hi,lo} result entries (legal range 1..4).
REQ-002 Parameter STARVE_LIMIT, default 8, SHALL set the number of consecutive lost arbitration cycles before writeback is held.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 wb_we  input  1  SHALL be the pipeline writeback write request (MEM/WB RegWrite).
REQ-006 wb_addr  input  5  SHALL be the writeback destination register.
REQ-007 wb_data  input  32  SHALL be the writeback data.
REQ-008 md_valid  input  1  SHALL indicate a mul/div result offered this cycle.
REQ-009 md_hi  input  32  SHALL be the $hi result.
REQ-010 md_lo  input  32  SHALL be the $lo result.
REQ-011 md_ready  output  1  SHALL indicate a result is accepted this cycle.
REQ-012 rf_we  output  1  SHALL be the register file write enable.
REQ-013 rf_addr  output  6  SHALL be the register file write index (0-31 general, 32 = $hi, 33 = $lo).
REQ-014 rf_data  output  32  SHALL be the register file write data.
REQ-015 wb_hold  output  1  SHALL request the pipeline to freeze MEM/WB so the writeback request is re-presented next cycle.
REQ-016 md_busy  output  1  SHALL indicate $hi/$lo writes pending, for mfhi/mflo hazard stalls.

Function
REQ-017 The FIFO SHALL hold DEPTH entries of {hi,lo}, in order, with a count 0..DEPTH.
REQ-018 md_ready SHALL be (count < DEPTH) && !reset, with no pass-through when full, even while popping.
REQ-019 A push SHALL occur when md_valid && md_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-020 The FSM SHALL have three states: IDLE, WR_HI, WR_LO.
REQ-021 IDLE SHALL move to WR_HI when count > 0, and otherwise stay in IDLE.
REQ-022 wb_req SHALL be wb_we && (wb_addr != 0); writes to register 0 SHALL never reach rf_we.
REQ-023 In IDLE, rf_we/rf_addr/rf_data SHALL be wb_req / {0,wb_addr} / wb_data, combinationally with zero latency.
REQ-024 In WR_HI/WR_LO with wb_req && !wb_hold, writeback SHALL win, the state SHALL hold, and starve_cnt SHALL increment.
REQ-025 Otherwise in WR_HI the block SHALL write addr 32 = head.hi and go to WR_LO.
REQ-026 Otherwise in WR_LO the block SHALL write addr 33 = head.lo, pop the head, and go to WR_HI if post-pop count > 0, else IDLE.
REQ-027 starve_cnt SHALL saturate at STARVE_LIMIT and clear on every $hi/$lo write.
REQ-028 wb_hold SHALL be (state != IDLE) && (starve_cnt == STARVE_LIMIT) && wb_req, combinationally; when high, the held writeback SHALL NOT be written that cycle.
REQ-029 md_busy SHALL be (count != 0).
REQ-030 When rf_we = 0, rf_addr and rf_data SHALL be 0.
REQ-031 A writeback and a $hi/$lo write SHALL never both be issued in one cycle.

Reset
REQ-032 A cycle with reset high SHALL force: state IDLE, count 0, FIFO pointers 0, starve_cnt 0.
REQ-033 During a reset cycle, rf_we, md_ready, wb_hold and md_busy SHALL be 0.
REQ-034 Reset mid-operation SHALL discard pending results, including a half-written entry with $hi done and $lo pending.

Verification
REQ-035 Idle pass-through: wb_we=1, wb_addr=5, wb_data=0xA5A5_0001 -> same cycle rf_we=1, rf_addr=5, rf_data=0xA5A5_0001; wb_addr=0 -> rf_we=0.
REQ-036 Single result, no writeback traffic: md_valid pulse at cycle N with hi=0x11, lo=0x22 -> addr 32 = 0x11 at N+2, addr 33 = 0x22 at N+3, md_busy high N+1..N+3, IDLE at N+4.
REQ-037 Back-to-back results: pushes at N and N+1 (DEPTH=2) -> writes in order hi0, lo0, hi1, lo1 at N+2..N+5 with no IDLE gap; a third md_valid at N+2 sees md_ready=0.
REQ-038 Starvation: continuous wb_req from WR_HI entry, STARVE_LIMIT=8 -> 8 writeback writes, then 9th cycle wb_hold=1 with $hi written and held writeback unwritten; repeats for $lo.
REQ-039 Reset after the $hi write, before the $lo write -> next cycle count=0, md_busy=0, no addr-33 write, state IDLE.
REQ-040 Full plus pop: count=2 in WR_LO with md_valid=1 -> md_ready=0, pop leaves count=1, and the offered result is accepted the following cycle.
